// File: rtl/alu6502_core.sv
// ---------------------------------------------------------------------------
// alu6502_core
// 6502 datapath arithmetic core. It contains the A/B operand latches, an 8-bit
// ALU (binary/BCD add, logic, shifts), a registered copy of the last carry,
// and the decimal-adjust adder on the accumulator write path.
//
// Ports
//   clk        : clock, all registers update on the rising edge
//   reset      : asynchronous, active-high; clears a_reg, b_reg and carry_last
//   a_in       : A operand, latched every cycle
//   b_in       : B operand, latched only when b_load=1
//   b_load     : B latch enable (0 = hold)
//   op         : ALU operation code
//   c_in       : live carry-in (combinational)
//   dec_add    : BCD addition mode for the ALU and the adjuster
//   dec_sub    : BCD subtraction adjust (the ALU itself stays binary)
//   adj_in     : value to decimal-adjust
//   alu_out    : ALU result
//   carry_out  : ALU carry out
//   hc_out     : ALU half carry (bit 3 -> bit 4)
//   v_out      : ALU signed overflow
//   carry_last : carry_out from the previous cycle
//   adj_out    : decimal-adjusted adj_in
// ---------------------------------------------------------------------------
module alu6502_core (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] a_in,
   input  logic [7:0] b_in,
   input  logic       b_load,
   input  logic [3:0] op,
   input  logic       c_in,
   input  logic       dec_add,
   input  logic       dec_sub,
   input  logic [7:0] adj_in,
   output logic [7:0] alu_out,
   output logic       carry_out,
   output logic       hc_out,
   output logic       v_out,
   output logic       carry_last,
   output logic [7:0] adj_out
);

   localparam logic [3:0] OP_ADC   = 4'd0;
   localparam logic [3:0] OP_SBC   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_EOR   = 4'd4;
   localparam logic [3:0] OP_SL    = 4'd5;
   localparam logic [3:0] OP_SR    = 4'd6;
   localparam logic [3:0] OP_PASSB = 4'd8;

   logic [7:0] a_reg;
   logic [7:0] b_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_reg      <= 8'h00;
         b_reg      <= 8'h00;
         carry_last <= 1'b0;
      end else begin
         a_reg      <= a_in;
         if (b_load)
            b_reg <= b_in;
         carry_last <= carry_out;
      end
   end

   // Adder: nibble-wise so the half carry (binary or BCD >9 detect) can feed
   // the high nibble. The sum itself is left unadjusted; the adjuster below
   // corrects it on the way into A.
   logic [4:0] lo_sum;
   logic [4:0] hi_sum;
   logic       arith_hc;
   logic       arith_c;
   logic [7:0] arith_out;

   always_comb begin
      lo_sum    = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'd0, c_in};
      arith_hc  = dec_add ? (lo_sum > 5'd9) : lo_sum[4];
      hi_sum    = {1'b0, a_reg[7:4]} + {1'b0, b_reg[7:4]} + {4'd0, arith_hc};
      arith_c   = dec_add ? (hi_sum > 5'd9) : hi_sum[4];
      arith_out = {hi_sum[3:0], lo_sum[3:0]};
   end

   always_comb begin
      alu_out   = a_reg;
      carry_out = 1'b0;
      hc_out    = 1'b0;
      v_out     = 1'b0;
      case (op)
         OP_ADC, OP_SBC: begin
            alu_out   = arith_out;
            carry_out = arith_c;
            hc_out    = arith_hc;
            v_out     = (a_reg[7] == b_reg[7]) & (arith_out[7] != a_reg[7]);
         end
         OP_AND:   alu_out = a_reg & b_reg;
         OP_OR:    alu_out = a_reg | b_reg;
         OP_EOR:   alu_out = a_reg ^ b_reg;
         OP_SL: begin
            alu_out   = {a_reg[6:0], c_in};
            carry_out = a_reg[7];
         end
         OP_SR: begin
            alu_out   = {c_in, a_reg[7:1]};
            carry_out = a_reg[0];
         end
         OP_PASSB: alu_out = b_reg;
         default:  alu_out = a_reg;
      endcase
   end

   // Decimal adjust: each nibble corrected independently, wrapping mod 16.
   logic [3:0] adj_lo;
   logic [3:0] adj_hi;

   always_comb begin
      adj_lo = adj_in[3:0];
      adj_hi = adj_in[7:4];
      if (dec_add) begin
         if (hc_out)
            adj_lo = adj_in[3:0] + 4'd6;
         if (carry_out)
            adj_hi = adj_in[7:4] + 4'd6;
      end else if (dec_sub) begin
         if (!hc_out)
            adj_lo = adj_in[3:0] - 4'd6;
         if (!carry_out)
            adj_hi = adj_in[7:4] - 4'd6;
      end
      adj_out = {adj_hi, adj_lo};
   end

endmodule

// File: tb/tb_alu6502_core.sv
// ---------------------------------------------------------------------------
// tb_alu6502_core
// Directed and randomized checks of alu6502_core against an arithmetic
// reference model of the ALU and decimal-adjust rules.
// ---------------------------------------------------------------------------
module tb_alu6502_core;

   logic       clk;
   logic       reset;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       b_load;
   logic [3:0] op;
   logic       c_in;
   logic       dec_add;
   logic       dec_sub;
   logic [7:0] adj_in;
   logic [7:0] alu_out;
   logic       carry_out;
   logic       hc_out;
   logic       v_out;
   logic       carry_last;
   logic [7:0] adj_out;

   alu6502_core dut (
      .clk        (clk),
      .reset      (reset),
      .a_in       (a_in),
      .b_in       (b_in),
      .b_load     (b_load),
      .op         (op),
      .c_in       (c_in),
      .dec_add    (dec_add),
      .dec_sub    (dec_sub),
      .adj_in     (adj_in),
      .alu_out    (alu_out),
      .carry_out  (carry_out),
      .hc_out     (hc_out),
      .v_out      (v_out),
      .carry_last (carry_last),
      .adj_out    (adj_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // model of the latched operands and of the registered carry
   int m_a  = 0;
   int m_b  = 0;
   int m_cl = 0;

   typedef struct {
      int out;
      int c;
      int hc;
      int v;
   } alu_res_t;

   function automatic alu_res_t ref_alu(int a, int b, int c, int opc, int dadd);
      alu_res_t r;
      int lo, hi;
      r.out = a; r.c = 0; r.hc = 0; r.v = 0;
      case (opc)
         0, 1: begin
            lo   = (a % 16) + (b % 16) + c;
            r.hc = dadd ? int'(lo > 9) : int'(lo >= 16);
            hi   = (a / 16) + (b / 16) + r.hc;
            r.c  = dadd ? int'(hi > 9) : int'(hi >= 16);
            r.out = (hi % 16) * 16 + (lo % 16);
            r.v  = int'(((a >= 128) == (b >= 128)) && ((r.out >= 128) != (a >= 128)));
         end
         2: r.out = a & b;
         3: r.out = a | b;
         4: r.out = a ^ b;
         5: begin r.out = (a * 2) % 256 + c; r.c = int'(a >= 128); end
         6: begin r.out = c * 128 + a / 2;   r.c = a % 2;          end
         8: r.out = b;
         default: r.out = a;
      endcase
      return r;
   endfunction

   function automatic int ref_adj(int v, int hc, int cy, int dadd, int dsub);
      int lo, hi;
      lo = v % 16;
      hi = v / 16;
      if (dadd) begin
         if (hc) lo = lo + 6;
         if (cy) hi = hi + 6;
      end else if (dsub) begin
         if (!hc) lo = lo + 10;
         if (!cy) hi = hi + 10;
      end
      return (hi % 16) * 16 + (lo % 16);
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_ctl(input int opc, input int c, input int da, input int ds, input int adj);
      op      = 4'(opc);
      c_in    = 1'(c);
      dec_add = 1'(da);
      dec_sub = 1'(ds);
      adj_in  = 8'(adj);
      #1;
   endtask

   // one clock: the carry captured is the one the model predicts for the
   // operands and controls present just before the edge
   task automatic clock_in(input int a, input int b, input int bl);
      alu_res_t r;
      a_in   = 8'(a);
      b_in   = 8'(b);
      b_load = 1'(bl);
      r = ref_alu(m_a, m_b, int'(c_in), int'(op), int'(dec_add));
      @(posedge clk);
      m_cl = r.c;
      m_a  = a;
      if (bl != 0) m_b = b;
      #1;
   endtask

   task automatic chk_model(input string tag);
      alu_res_t r;
      int adj;
      r   = ref_alu(m_a, m_b, int'(c_in), int'(op), int'(dec_add));
      adj = ref_adj(int'(adj_in), r.hc, r.c, int'(dec_add), int'(dec_sub));
      chk({tag, "_out"}, int'(alu_out), r.out);
      chk({tag, "_c"},   int'(carry_out), r.c);
      chk({tag, "_hc"},  int'(hc_out), r.hc);
      chk({tag, "_v"},   int'(v_out), r.v);
      chk({tag, "_adj"}, int'(adj_out), adj);
      chk({tag, "_cl"},  int'(carry_last), m_cl);
   endtask

   initial begin
      reset = 1'b1;
      a_in = 8'h00; b_in = 8'h00; b_load = 1'b0;
      op = 4'd0; c_in = 1'b0; dec_add = 1'b0; dec_sub = 1'b0; adj_in = 8'h00;
      repeat (2) @(posedge clk);
      #2;
      set_ctl(7, 0, 0, 0, 0);
      chk("rst_a", int'(alu_out), 0);
      set_ctl(8, 0, 0, 0, 0);
      chk("rst_b", int'(alu_out), 0);
      chk("rst_cl", int'(carry_last), 0);
      reset = 1'b0;

      // binary ADC 0x50+0x50
      set_ctl(0, 0, 0, 0, 0);
      clock_in(8'h50, 8'h50, 1);
      chk("bin_out", int'(alu_out), 8'hA0);
      chk("bin_c", int'(carry_out), 0);
      chk("bin_v", int'(v_out), 1);
      chk("bin_hc", int'(hc_out), 0);
      clock_in(8'h50, 8'h50, 1);
      chk("bin_cl", int'(carry_last), 0);

      // BCD ADC 19+28
      set_ctl(0, 0, 1, 0, 8'h41);
      clock_in(8'h19, 8'h28, 1);
      chk("bcd_out", int'(alu_out), 8'h41);
      chk("bcd_hc", int'(hc_out), 1);
      chk("bcd_c", int'(carry_out), 0);
      chk("bcd_adj", int'(adj_out), 8'h47);

      // BCD wrap 99+01: unadjusted sum is AA, adjusting it gives 00
      set_ctl(0, 0, 1, 0, 8'hAA);
      clock_in(8'h99, 8'h01, 1);
      chk("wrap_c", int'(carry_out), 1);
      chk("wrap_out", int'(alu_out), 8'hAA);
      chk("wrap_adj", int'(adj_out), 8'h00);
      clock_in(8'h00, 8'h00, 1);
      chk("wrap_cl", int'(carry_last), 1);

      // BCD SBC 50-01
      set_ctl(1, 1, 0, 1, 8'h4F);
      clock_in(8'h50, 8'hFE, 1);
      chk("sbc_out", int'(alu_out), 8'h4F);
      chk("sbc_c", int'(carry_out), 1);
      chk("sbc_hc", int'(hc_out), 0);
      chk("sbc_adj", int'(adj_out), 8'h49);
      set_ctl(1, 1, 1, 1, 8'h4F);
      chk_model("both_dec");

      // shifts and logic
      set_ctl(5, 0, 0, 0, 0);
      clock_in(8'h81, 8'h3C, 1);
      chk("sl_out", int'(alu_out), 8'h02);
      chk("sl_c", int'(carry_out), 1);
      set_ctl(6, 1, 0, 0, 0);
      clock_in(8'h01, 8'h3C, 1);
      chk("sr_out", int'(alu_out), 8'h80);
      chk("sr_c", int'(carry_out), 1);
      set_ctl(2, 0, 0, 0, 0);
      clock_in(8'hF0, 8'h3C, 1);
      chk("and_out", int'(alu_out), 8'h30);
      chk("and_c", int'(carry_out), 0);

      // B hold
      set_ctl(8, 0, 0, 0, 0);
      clock_in(8'h00, 8'h11, 1);
      clock_in(8'h00, 8'h22, 0);
      chk("hold_b", int'(alu_out), 8'h11);
      set_ctl(0, 0, 0, 0, 0);
      clock_in(8'h05, 8'h33, 0);
      set_ctl(8, 0, 0, 0, 0);
      chk("hold_b2", int'(alu_out), 8'h11);

      // mid-cycle reset with non-zero state and carry_last=1
      set_ctl(0, 1, 0, 0, 0);
      clock_in(8'hFF, 8'hFF, 1);
      clock_in(8'hFF, 8'hFF, 1);
      chk("pre_rst_cl", int'(carry_last), 1);
      reset = 1'b1;
      #1;
      set_ctl(7, 0, 0, 0, 0);
      chk("mid_rst_a", int'(alu_out), 0);
      set_ctl(8, 0, 0, 0, 0);
      chk("mid_rst_b", int'(alu_out), 0);
      chk("mid_rst_cl", int'(carry_last), 0);
      reset = 1'b0;
      m_a = 0; m_b = 0; m_cl = 0;

      // randomized sweep against the model
      for (int i = 0; i < 300; i++) begin
         clock_in(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)));
         set_ctl(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)));
         chk_model("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
